// File: rtl/conv1d_ktap_pkg.sv
// Shared definitions for the shift-weight convolution lane: weight-code field
// positions, default widths, accumulator sizing and signed saturation helpers.
package conv1d_ktap_pkg;

  localparam int DEF_ACT_W   = 12;
  localparam int DEF_WCODE_W = 5;
  localparam int DEF_OUT_W   = 24;

  // Weight code layout, MSB first: {nz, sign, exp}.
  localparam int WC_EXP_LSB = 0;

  function automatic int wc_nz_bit(input int wcode_w);
    return wcode_w - 1;
  endfunction

  function automatic int wc_sign_bit(input int wcode_w);
    return wcode_w - 2;
  endfunction

  function automatic int wc_exp_msb(input int wcode_w);
    return wcode_w - 3;
  endfunction

  // Wide enough for K full-scale products at the largest shift, including negation.
  function automatic int acc_width(input int act_w, input int wcode_w, input int k);
    return act_w + (1 << (wcode_w - 2)) - 1 + $clog2(k) + 1;
  endfunction

  function automatic logic signed [63:0] sat_hi(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

  // Clip v into the signed out_w range; callers truncate the result to out_w bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int out_w);
    logic signed [63:0] res;
    res = v;
    if (v > sat_hi(out_w)) res = sat_hi(out_w);
    else if (v < sat_lo(out_w)) res = sat_lo(out_w);
    return res;
  endfunction

  function automatic logic sat_clipped(input logic signed [63:0] v, input int out_w);
    return (v > sat_hi(out_w)) || (v < sat_lo(out_w));
  endfunction

endpackage

// File: rtl/conv1d_ktap_shift_tap.sv
// One tap of the lane: decodes a power-of-two weight code and applies it to an
// activation as an exact sign-extended shift with optional negation.
module shift_tap
  import conv1d_ktap_pkg::*;
#(
  parameter int ACT_W   = DEF_ACT_W,
  parameter int WCODE_W = DEF_WCODE_W,
  parameter int ACC_W   = acc_width(DEF_ACT_W, DEF_WCODE_W, 3)
) (
  input  logic [ACT_W-1:0]   i_act,
  input  logic [WCODE_W-1:0] i_code,
  output logic [ACC_W-1:0]   o_prod
);

  localparam int NZ_BIT   = wc_nz_bit(WCODE_W);
  localparam int SIGN_BIT = wc_sign_bit(WCODE_W);
  localparam int EXP_MSB  = wc_exp_msb(WCODE_W);

  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_shifted;
  logic [EXP_MSB:WC_EXP_LSB] w_exp;

  assign w_ext     = {{(ACC_W - ACT_W){i_act[ACT_W-1]}}, i_act};
  assign w_exp     = i_code[EXP_MSB:WC_EXP_LSB];
  assign w_shifted = w_ext <<< w_exp;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_prod = '0;
    if (i_code[NZ_BIT]) o_prod = i_code[SIGN_BIT] ? -w_shifted : w_shifted;
  end

endmodule

// File: rtl/conv1d_ktap.sv
// K-tap 1D convolution lane with power-of-two weights, a shadow/active weight
// bank pair, per-row warm-up masking, optional 1x1 mode and saturating output.
module conv1d_ktap
  import conv1d_ktap_pkg::*;
#(
  parameter int K       = 3,
  parameter int ACT_W   = DEF_ACT_W,
  parameter int WCODE_W = DEF_WCODE_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ACT_W-1:0]   act_data,
  input  logic               act_valid,
  input  logic               act_first,
  input  logic               mode_1x1,
  input  logic [WCODE_W-1:0] weight_data,
  input  logic               weight_valid,
  input  logic               weight_switch,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  output logic               out_sat
);

  localparam int ACC_W = acc_width(ACT_W, WCODE_W, K);
  localparam int CNT_W = $clog2(K + 1);

  logic [WCODE_W-1:0]      r_shadow [K];
  logic [WCODE_W-1:0]      r_active [K];
  logic [ACT_W-1:0]        r_x;
  logic                    r_xv;
  logic                    r_xf;
  logic                    r_mode;
  logic signed [ACC_W-1:0] r_acc [K-1];
  logic [CNT_W-1:0]        r_cnt;
  logic [OUT_W-1:0]        r_out_data;
  logic                    r_out_valid;
  logic                    r_out_sat;

  logic signed [ACC_W-1:0] w_prod [K];
  logic signed [ACC_W-1:0] w_pick;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_valid_next;
  logic [OUT_W-1:0]        w_sat_data;
  logic                    w_clip;

  // NOTE: the small weight banks are reset explicitly so every product is 0 out of reset.
  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < K; j++) begin
        r_shadow[j] <= '0;
        r_active[j] <= '0;
      end
    end else begin
      // Commit reads the pre-shift shadow when a load lands in the same cycle.
      if (weight_switch) begin
        if (r_mode) r_active[0] <= r_shadow[K-1];
        else for (int j = 0; j < K; j++) r_active[j] <= r_shadow[j];
      end
      if (weight_valid) begin
        for (int j = 0; j < K - 1; j++) r_shadow[j] <= r_shadow[j+1];
        r_shadow[K-1] <= weight_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_xv   <= 1'b0;
      r_xf   <= 1'b0;
      r_mode <= 1'b0;
    end else begin
      r_x  <= act_data;
      r_xv <= act_valid;
      r_xf <= act_first;
      if (act_valid && act_first) r_mode <= mode_1x1;
    end
  end

  for (genvar j = 0; j < K; j++) begin : g_tap
    shift_tap #(
      .ACT_W  (ACT_W),
      .WCODE_W(WCODE_W),
      .ACC_W  (ACC_W)
    ) u_tap (
      .i_act (r_x),
      .i_code(r_active[j]),
      .o_prod(w_prod[j])
    );
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (r_xf) w_cnt_next = CNT_W'(1);
    else if (r_cnt < CNT_W'(K)) w_cnt_next = r_cnt + CNT_W'(1);
  end

  always_comb begin
    w_pick = r_acc[K-2] + w_prod[K-1];
    if (r_mode) w_pick = w_prod[0];
  end

  assign w_valid_next = r_mode || (w_cnt_next >= CNT_W'(K));
  assign w_sat_data   = OUT_W'(sat_signed(64'(w_pick), OUT_W));
  assign w_clip       = sat_clipped(64'(w_pick), OUT_W);

  // Transposed chain: acc[j] holds the partial sum of taps 0..j; gaps freeze it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < K - 1; j++) r_acc[j] <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
    end else if (r_xv) begin
      r_acc[0] <= w_prod[0];
      for (int j = 1; j < K - 1; j++) r_acc[j] <= r_xf ? w_prod[j] : r_acc[j-1] + w_prod[j];
      r_cnt       <= w_cnt_next;
      r_out_data  <= w_sat_data;
      r_out_valid <= w_valid_next;
      r_out_sat   <= w_valid_next && w_clip;
    end else begin
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_conv1d_ktap.sv
// Bench for conv1d_ktap: a directed vector table, hand-written reset and
// load/commit collision sequences, then randomized rows against a reference model.
module tb_conv1d_ktap;

  localparam int K = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] act_data;
  logic        act_valid, act_first, mode_1x1;
  logic [4:0]  weight_data;
  logic        weight_valid, weight_switch;
  logic [23:0] o24_data;
  logic        o24_valid, o24_sat;
  logic [7:0]  o8_data;
  logic        o8_valid, o8_sat;

  always #5 clk = ~clk;

  conv1d_ktap #(.K(K), .ACT_W(12), .WCODE_W(5), .OUT_W(24)) dut (
    .clk(clk), .rst(rst), .act_data(act_data), .act_valid(act_valid),
    .act_first(act_first), .mode_1x1(mode_1x1), .weight_data(weight_data),
    .weight_valid(weight_valid), .weight_switch(weight_switch),
    .out_data(o24_data), .out_valid(o24_valid), .out_sat(o24_sat)
  );

  conv1d_ktap #(.K(K), .ACT_W(12), .WCODE_W(5), .OUT_W(8)) dut_s (
    .clk(clk), .rst(rst), .act_data(act_data), .act_valid(act_valid),
    .act_first(act_first), .mode_1x1(mode_1x1), .weight_data(weight_data),
    .weight_valid(weight_valid), .weight_switch(weight_switch),
    .out_data(o8_data), .out_valid(o8_valid), .out_sat(o8_sat)
  );

  typedef struct { bit v; longint y; } exp_t;
  typedef struct {
    bit av; bit af; bit md; int act; bit wv; int wd; bit ws; bit ev; longint ey;
  } vec_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  string phase    = "reset";
  exp_t  pipe_a   = '{0, 0};
  exp_t  pipe_b   = '{0, 0};
  vec_t  tbl[$];

  // Reference model state: weights as codes, current row as a list of samples.
  int     m_shadow[$];
  int     m_active[K];
  bit     m_mode;
  longint m_row[$];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got %0d, expected %0d", phase, name, act, exp);
  endtask

  function automatic longint clip(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic check_outputs(input exp_t e);
    check("valid24", o24_valid, e.v);
    check("sat24", o24_sat, e.v && (clip(e.y, 24) != e.y));
    if (e.v) check("data24", $signed(o24_data), clip(e.y, 24));
    check("valid8", o8_valid, e.v);
    check("sat8", o8_sat, e.v && (clip(e.y, 8) != e.y));
    if (e.v) check("data8", $signed(o8_data), clip(e.y, 8));
  endtask

  task automatic check_zero();
    @(negedge clk);
    check("zero_data24", $signed(o24_data), 0);
    check("zero_valid24", o24_valid, 0);
    check("zero_sat24", o24_sat, 0);
    check("zero_data8", $signed(o8_data), 0);
    check("zero_valid8", o8_valid, 0);
    check("zero_sat8", o8_sat, 0);
  endtask

  // One clock of stimulus; the expectation for this sample is checked 2 cycles later.
  task automatic cycle(input bit rs, input bit av, input bit af, input bit md,
                       input int act, input bit wv, input int wd, input bit ws,
                       input bit ev, input longint ey);
    @(negedge clk);
    check_outputs(pipe_a);
    pipe_a = pipe_b;
    pipe_b = '{ev, ey};
    if (rs) begin
      pipe_a = '{0, 0};
      pipe_b = '{0, 0};
    end
    rst           = rs;
    act_valid     = av;
    act_first     = af;
    mode_1x1      = md;
    act_data      = 12'(act);
    weight_valid  = wv;
    weight_data   = 5'(wd);
    weight_switch = ws;
  endtask

  function automatic longint wval(input int code);
    longint mag;
    mag = longint'(1) <<< (code & 7);
    if (((code >> 4) & 1) == 0) return 0;
    return (((code >> 3) & 1) != 0) ? -mag : mag;
  endfunction

  task automatic m_reset();
    m_shadow = {};
    repeat (K) m_shadow.push_back(0);
    for (int k = 0; k < K; k++) m_active[k] = 0;
    m_mode = 1'b0;
    m_row  = {};
  endtask

  task automatic rstep(input bit rs, input bit av, input bit af, input bit md,
                       input int act, input bit wv, input int wd, input bit ws);
    exp_t e;
    int   n;
    e = '{0, 0};
    if (rs) m_reset();
    else begin
      if (ws) begin
        if (m_mode) m_active[0] = m_shadow[K-1];
        else for (int k = 0; k < K; k++) m_active[k] = m_shadow[k];
      end
      if (wv) begin
        m_shadow.push_back(wd);
        void'(m_shadow.pop_front());
      end
      if (av) begin
        if (af) begin
          m_mode = md;
          m_row  = {};
        end
        m_row.push_back(act);
        n = m_row.size();
        if (m_mode) e = '{1, wval(m_active[0]) * act};
        else if (n >= K) begin
          e.v = 1;
          for (int k = 0; k < K; k++) e.y += wval(m_active[k]) * m_row[n-K+k];
        end
      end
    end
    cycle(rs, av, af, md, act, wv, wd, ws, e.v, e.y);
  endtask

  task automatic t_w(input int code); tbl.push_back('{0, 0, 0, 0, 1, code, 0, 0, 0}); endtask
  task automatic t_s(); tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 0}); endtask
  task automatic t_i(input int n); repeat (n) tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0}); endtask
  task automatic t_a(input bit af, input bit md, input int act, input bit ev, input longint ey);
    tbl.push_back('{1, af, md, act, 0, 0, 0, ev, ey});
  endtask

  initial begin
    logic signed [11:0] r_act;
    bit md;
    int len;

    // Directed table: expected values belong to the sample on the same row.
    t_w(5'h10); t_w(5'h11); t_w(5'h1A); t_s();
    t_a(1, 0, 1, 0, 0); t_a(0, 0, 2, 0, 0); t_a(0, 0, 3, 1, -7); t_a(0, 0, 4, 1, -8); t_i(2);
    t_a(1, 0, 1, 0, 0); t_i(3); t_a(0, 0, 2, 0, 0); t_i(3);
    t_a(0, 0, 3, 1, -7); t_i(3); t_a(0, 0, 4, 1, -8); t_i(3);
    t_a(1, 0, 1, 0, 0); t_a(0, 0, 2, 0, 0); t_a(0, 0, 3, 1, -7);
    t_a(1, 0, 10, 0, 0); t_a(0, 0, 20, 0, 0); t_a(0, 0, 30, 1, -70); t_i(2);
    t_a(1, 1, 0, 1, 0); t_i(1); t_w(5'h11); t_s();
    t_a(1, 1, 5, 1, 10); t_a(0, 0, -3, 1, -6); t_i(2);
    t_a(1, 0, 1, 0, 0); t_a(0, 0, 2, 0, 0); t_a(0, 0, 3, 1, -6); t_i(1);
    t_w(0); t_w(0); t_w(5'h17); t_s();
    t_a(1, 0, 0, 0, 0); t_a(0, 0, 0, 0, 0); t_a(0, 0, 2047, 1, 262016);
    t_a(1, 0, 0, 0, 0); t_a(0, 0, 0, 0, 0); t_a(0, 0, -2048, 1, -262144); t_i(2);

    rst = 1'b1; act_valid = 0; act_first = 0; mode_1x1 = 0; act_data = '0;
    weight_valid = 0; weight_data = '0; weight_switch = 0;
    repeat (2) @(posedge clk);
    check_zero();

    phase = "table";
    foreach (tbl[i])
      cycle(0, tbl[i].av, tbl[i].af, tbl[i].md, tbl[i].act, tbl[i].wv, tbl[i].wd,
            tbl[i].ws, tbl[i].ev, tbl[i].ey);

    // Reset mid-row: sample 4's result must never appear; weights return to zero.
    phase = "reset_mid_row";
    cycle(0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 2, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 3, 0, 0, 0, 1, 384);
    cycle(0, 1, 0, 0, 4, 0, 0, 0, 1, 512);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_zero();
    cycle(0, 1, 1, 0, 5, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 6, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 7, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load and commit together: commit sees {+1,+2,-4}, not the shifted bank.
    phase = "collision";
    cycle(0, 0, 0, 0, 0, 1, 5'h10, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 5'h11, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 5'h1A, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 5'h17, 1, 0, 0);
    cycle(0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 2, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 3, 0, 0, 0, 1, -7);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 2, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 3, 0, 0, 0, 1, 378);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    phase = "random";
    m_reset();
    rstep(1, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 200; r++) begin
      rstep(0, 0, 0, 1'($urandom), 0, 0, 0, 0);
      repeat ($urandom_range(0, K + 1)) rstep(0, 0, 0, 0, 0, 1, int'($urandom_range(0, 31)), 0);
      if ($urandom_range(0, 1) == 1) rstep(0, 0, 0, 0, 0, 0, 0, 1);
      md  = ($urandom_range(0, 3) == 0);
      len = int'($urandom_range(1, 6));
      for (int s = 0; s < len; s++) begin
        repeat ($urandom_range(0, 2))
          rstep(0, 0, 0, 1'($urandom), 0, 1'($urandom), int'($urandom_range(0, 31)), 0);
        r_act = 12'($urandom);
        rstep(0, 1, s == 0, (s == 0) ? md : 1'($urandom), r_act, 0, 0, 0);
        if ($urandom_range(0, 39) == 0) rstep(1, 0, 0, 0, 0, 0, 0, 0);
      end
    end
    repeat (3) rstep(0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv1d_ktap.md
Name: conv1d_ktap

Overview:
- Parametrised K-tap 1D convolution lane with shift-based (power-of-two) weights and double-buffered weight registers.
- Successor to the fixed 3-tap lane; adds run-time 1x1 mode, row warm-up masking, act_valid gap tolerance and output saturation.
- Sits between the activation line buffer and the inter-row accumulator; one instance per output channel lane.

Parameters:
- K, 3, taps per lane, 2..7 (1x1 mode uses tap 0 only).
- ACT_W, 12, signed activation width.
- WCODE_W, 5, weight code width: {nz, sign, exp[WCODE_W-3:0]}.
- OUT_W, 24, signed output width; saturating.
- ACC_W, derived, ACT_W + 2^(WCODE_W-2) - 1 + clog2(K) + 1; internal, not overridable.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- act_data, in, ACT_W, signed activation sample.
- act_valid, in, 1, sample qualifier; gaps allowed.
- act_first, in, 1, with act_valid: first sample of a row.
- mode_1x1, in, 1, kernel mode, sampled only on act_valid & act_first.
- weight_data, in, WCODE_W, weight code.
- weight_valid, in, 1, shift weight_data into the shadow bank.
- weight_switch, in, 1, commit shadow bank to active bank.
- out_data, out, OUT_W, signed saturated result.
- out_valid, out, 1, out_data qualifier.
- out_sat, out, 1, pulses with out_valid when the result was clipped.

Behaviour:
- Reset, synchronous, high at a clk edge: every register cleared; out_data=0, out_valid=0, out_sat=0; shadow and active codes = 0 (product 0); warm-up counter=0; mode_q=0. Reset mid-row discards all in-flight data. No output for 2 cycles after release.
- Weight code: nz=0 gives product 0. Otherwise product = (sign ? -1 : 1) * (act << exp), sign-extended to ACC_W. Exact, no truncation.
- Shadow bank: on weight_valid, shadow[K-1] <= weight_data and shadow[j] <= shadow[j+1]. The first of K loads ends in shadow[0].
- weight_switch, K-tap mode: active[j] <= shadow[j] for all j.
- weight_switch, 1x1 mode (mode_q=1): active[0] <= shadow[K-1], the most recent load; other taps unchanged.
- weight_valid and weight_switch in the same cycle: the commit uses the pre-shift shadow.
- weight_switch must not coincide with a registered valid sample mid-row. The bench never does this, and the result is undefined.
- Stage 1, input register: x <= act_data; xv <= act_valid; xf <= act_first.
  - On act_valid & act_first: mode_q <= mode_1x1.
- Stage 2, transposed accumulate chain, updates only when xv=1 (gaps freeze the chain):
  - acc[0] <= p0.
  - acc[j] <= acc[j-1] + pj, for j = 1..K-1.
  - With xf=1, acc[j] <= pj for j>=1 (previous row flushed).
  - y[n] = sum over k of w_k * x[n-K+1+k]; w_0 multiplies the oldest sample.
- Warm-up counter: per row, saturates at K; xf loads 1, otherwise increments on xv.
- Output register, when xv=1:
  - K-tap mode: out_data <= sat(acc[K-2] + p_{K-1}); out_valid <= (count including this sample >= K).
  - 1x1 mode: out_data <= sat(p0); out_valid <= 1.
  - When xv=0: out_valid <= 0 and out_data holds its value.
- Latency: 2 clk from the act_valid of the completing sample to out_valid, in both modes.
- Saturation: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 when clipped.

Decomposition:
- Shared package holds:
  - weight-code field positions (NZ, SIGN, EXP lsb/msb);
  - default ACT_W/WCODE_W/OUT_W;
  - ACC_W helper function;
  - signed saturate function, reused by the inter-row accumulator.
- One sub-module, shift_tap (combinational code decode plus shift/negate, ACT_W to ACC_W), instantiated K times via generate.

Test Plan:
- Basic K-tap: K=3. Load codes 5'h10(+1), 5'h11(+2), 5'h1A(-4), then weight_switch. Acts 1,2,3,4 with act_first on 1 -> out_valid only for samples 3 and 4, data -7 then -8, each 2 cycles after its act_valid.
- Gaps: same stimulus with 3 idle cycles between every sample -> identical outputs (-7, -8), each 2 cycles after its own act_valid.
- Row restart: row A=1,2,3 then row B=10,20,30 with act_first on 10 -> outputs -7, then -70; no output for 10 or 20.
- 1x1 mode: mode_1x1=1 at act_first, last loaded code 5'h11, weight_switch. Acts 5,-3 -> out_data 10 then -6, both valid, latency 2.
- Saturation: OUT_W=8, shadow loaded {0,0,5'h17} (+128 on tap 2). Acts 0,0,2047 -> out 127, out_sat=1. Act -2048 as the 3rd sample -> out -128, out_sat=1.
- Reset/collision: rst mid-row -> out_valid=0 on the following edge; a new row without reloading gives out_data 0. weight_valid+weight_switch together -> active bank equals the pre-shift shadow.
